// File: rtl/fc_argmax.sv
`default_nettype none
// ============================================================================
// Module   : fc_argmax
// Purpose  : Sequential argmax over a flattened vector of signed logits.
//            A whole vector is captured in one handshake and scanned one
//            element per clock. The winning index and value are held until
//            downstream accepts them.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            in_valid/in_ready   - vector handshake (ready only in IDLE)
//            logits              - NUM_CLASSES x DATA_W flattened vector,
//                                  element k at [k*DATA_W +: DATA_W]
//            out_valid/out_ready - result handshake
//            class_id, max_logit - registered result
//            busy                - high while scanning or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*NUM_CLASSES-1:0] logits,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              class_id,
  output logic [DATA_W-1:0]             max_logit,
  output logic                          busy
);

  localparam bit               SINGLE   = (NUM_CLASSES == 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [DATA_W*NUM_CLASSES-1:0]   vec_q, vec_d;
  logic [DATA_W-1:0]               best_val_q, best_val_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            out_valid_q, out_valid_d;
  logic [IDX_W-1:0]                class_id_q, class_id_d;
  logic [DATA_W-1:0]               max_logit_q, max_logit_d;

  logic [DATA_W-1:0]               scan_elem;
  logic [DATA_W-1:0]               cand_val;
  logic [IDX_W-1:0]                cand_idx;

  // Select the captured element currently under inspection.
  always_comb begin
    scan_elem = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        scan_elem = vec_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    cand_val = best_val_q;
    cand_idx = best_idx_q;
    if ($signed(scan_elem) > $signed(best_val_q)) begin
      cand_val = scan_elem;
      cand_idx = idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    class_id_d  = class_id_q;
    max_logit_d = max_logit_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vec_d      = logits;
          best_val_d = logits[DATA_W-1:0];
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
          if (SINGLE) begin
            // Element 0 is already the answer; publish it immediately.
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            class_id_d  = '0;
            max_logit_d = logits[DATA_W-1:0];
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        best_val_d = cand_val;
        best_idx_d = cand_idx;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Result registers take the final comparison outcome directly.
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          class_id_d  = cand_idx;
          max_logit_d = cand_val;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      class_id_q  <= '0;
      max_logit_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      class_id_q  <= class_id_d;
      max_logit_q <= max_logit_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign class_id  = class_id_q;
  assign max_logit = max_logit_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_argmax
// Purpose  : Self-checking bench for fc_argmax (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_argmax;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int VW = NC * DW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] logits;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_id;
  logic [DW-1:0] max_logit;
  logic          busy;

  fc_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .logits    (logits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_id  (class_id),
    .max_logit (max_logit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) pulses <= pulses + 1;
  end

  typedef struct {
    logic [VW-1:0] v;
    logic [IW-1:0] id;
    logic [DW-1:0] val;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] setel(input logic [VW-1:0] v, input int k, input logic [DW-1:0] x);
    logic [VW-1:0] r;
    r = v;
    r[k*DW +: DW] = x;
    return r;
  endfunction

  // Reference: first index holding the largest signed value.
  function automatic void ref_argmax(input logic [VW-1:0] v, output logic [IW-1:0] id,
                                     output logic [DW-1:0] val);
    logic [DW-1:0] e;
    int best, cur, bi;
    e    = v[DW-1:0];
    best = int'($signed(e));
    bi   = 0;
    for (int k = 1; k < NC; k++) begin
      e   = v[k*DW +: DW];
      cur = int'($signed(e));
      if (cur > best) begin
        best = cur;
        bi   = k;
      end
    end
    id  = IW'(bi);
    val = DW'(best);
  endfunction

  function automatic logic [VW-1:0] rand_vec(input bit narrow);
    logic [VW-1:0] r;
    for (int k = 0; k < NC; k++) begin
      if (narrow) r[k*DW +: DW] = DW'(int'($urandom_range(0, 4)) - 2);
      else        r[k*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  // Wait (bounded) until out_valid; returns the number of edges waited.
  task automatic wait_out(input string name, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      chk({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
    end
  endtask

  // One full transaction from IDLE with out_ready already high.
  task automatic apply(input string name, input logic [VW-1:0] v,
                       input logic [IW-1:0] eid, input logic [DW-1:0] ev);
    int n;
    chk({name, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    logits    = v;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    logits   = rand_vec(1'b0);
    wait_out(name, n);
    chk({name, "_latency"}, 32'(n), 32'd9);
    chk({name, "_class_id"}, 32'(class_id), 32'(eid));
    chk({name, "_max_logit"}, 32'(max_logit), 32'(ev));
    @(posedge clk); #1;
    chk({name, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({name, "_id_held"}, 32'(class_id), 32'(eid));
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [IW-1:0] rid;
    logic [DW-1:0] rval;
    logic [VW-1:0] bb[4];
    int n, acc, prev, p0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; logits = '0;

    // Directed vectors with hand-derived answers.
    v = '0;
    for (int k = 0; k < NC; k++) v = setel(v, k, DW'(10 * k));
    tbl[0] = '{v, 4'd9, 16'd90};
    v = '0; v = setel(v, 3, 16'h7FFF); v = setel(v, 5, 16'h8000);
    tbl[1] = '{v, 4'd3, 16'h7FFF};
    v = '0;
    for (int k = 0; k < NC; k++) v = setel(v, k, DW'(-(k * 100 + 5)));
    v = setel(v, 7, 16'hFFFF);
    tbl[2] = '{v, 4'd7, 16'hFFFF};
    v = '0;
    for (int k = 0; k < NC; k++) v = setel(v, k, 16'd100);
    v = setel(v, 2, 16'd500); v = setel(v, 6, 16'd500);
    tbl[3] = '{v, 4'd2, 16'd500};
    v = '0;
    for (int k = 0; k < NC; k++) v = setel(v, k, 16'd42);
    tbl[4] = '{v, 4'd0, 16'd42};
    v = '0;
    for (int k = 0; k < NC; k++) v = setel(v, k, 16'h8000);
    v = setel(v, 0, 16'h8001);
    tbl[5] = '{v, 4'd0, 16'h8001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_class_id", 32'(class_id), 32'd0);
    chk("reset_max_logit", 32'(max_logit), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) apply($sformatf("tbl%0d", i), tbl[i].v, tbl[i].id, tbl[i].val);

    for (int i = 0; i < 20; i++) begin
      v = rand_vec(i[0]);
      ref_argmax(v, rid, rval);
      apply($sformatf("rnd%0d", i), v, rid, rval);
    end

    // Backpressure: hold DONE while inputs churn.
    v = rand_vec(1'b0);
    ref_argmax(v, rid, rval);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    logits    = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp", n);
    chk("bp_latency", 32'(n), 32'd9);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom);
      logits   = rand_vec(1'b0);
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_id", 32'(class_id), 32'(rid));
      chk("bp_hold_val", 32'(max_logit), 32'(rval));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_id", 32'(class_id), 32'(rid));
    @(posedge clk); #1;
    chk("bp_no_capture", 32'(busy), 32'd0);

    // Reset mid-scan, asserted between edges.
    in_valid = 1'b1;
    logits   = tbl[0].v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_class_id", 32'(class_id), 32'd0);
    chk("rst_mid_max_logit", 32'(max_logit), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_idle", 32'(busy), 32'd0);
    apply("post_rst", tbl[2].v, tbl[2].id, tbl[2].val);

    // Back-to-back: in_valid stays high, next vector ready each time.
    for (int i = 0; i < 4; i++) bb[i] = rand_vec(i[0]);
    p0 = pulses;
    prev = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logits = bb[i];
      n = 0;
      while (!in_ready && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) begin
        errors++;
        $display("FAIL b2b_ready_timeout actual=no_in_ready required=in_ready");
      end
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) chk("b2b_spacing", 32'(acc - prev), 32'd11);
      prev = acc;
      logits = rand_vec(1'b0);
      wait_out("b2b", n);
      ref_argmax(bb[i], rid, rval);
      chk("b2b_class_id", 32'(class_id), 32'(rid));
      chk("b2b_max_logit", 32'(max_logit), 32'(rval));
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_result_count", 32'(pulses - p0), 32'd4);
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_argmax.md
# fc_argmax

Sequential argmax classifier that consumes the flattened logit vector produced by the fully-connected layer and reports the winning class index and its logit value. It sits at the tail of the inference pipeline, between the fully-connected stage and the result/display logic. It captures the whole vector in one handshake, scans it one element per cycle, and holds the result until it is accepted downstream.

## Interface
- NUM_CLASSES, default 10: number of logits per vector; must be >= 1.
- DATA_W, default 16: width of each logit in bits.
- IDX_W, default 4: width of class_id; must satisfy 2^IDX_W >= NUM_CLASSES.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  logits holds a valid vector.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- logits  input  DATA_W*NUM_CLASSES  flattened vector; element k occupies bits [k*DATA_W +: DATA_W]; two's-complement signed.
- out_valid  output  1  class_id and max_logit are valid.
- out_ready  input  1  downstream accepts the result.
- class_id  output  IDX_W  index of the maximum logit.
- max_logit  output  DATA_W  value of the maximum logit.
- busy  output  1  high in SCAN or DONE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - Register the entire logits vector into an internal copy. The input may change after this edge.
  - best_val <= element 0; best_idx <= 0; scan index <= 1.
  - Go to SCAN. If NUM_CLASSES==1, go directly to DONE.
- SCAN: each edge compares the captured element[idx] with best_val as signed values.
  - If element[idx] > best_val (strict), update best_val and best_idx to idx.
  - idx increments by 1.
  - The edge that processes idx = NUM_CLASSES-1 moves to DONE and sets out_valid=1.
- Ties keep the lowest index. A vector of all-equal values yields class_id=0.
- DONE: out_valid=1. class_id=best_idx and max_logit=best_val, held stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - class_id and max_logit keep their last values.
- in_valid is ignored outside IDLE; no vector is accepted while busy.
- No arithmetic beyond comparison. Values pass through unmodified at full DATA_W. No saturation or truncation.
- Reset, asynchronous, at any time including mid-SCAN or DONE:
  - state=IDLE; out_valid=0; class_id=0; max_logit=0; busy=0; in_ready=1.
  - The captured vector and the scan index are discarded.
  - After reset is released, the first edge with in_valid=1 starts a fresh capture.

## Timing
- in_ready is combinational from state only. It does not depend on in_valid or out_ready.
- Acceptance edge E0. Compare edges E1..E(NUM_CLASSES-1). out_valid is high after edge E(NUM_CLASSES-1).
  - Latency from acceptance to out_valid = NUM_CLASSES-1 edges; 9 for the default.
  - For NUM_CLASSES==1, out_valid is high right after E0.
- If out_ready is already high when out_valid rises, the result is accepted on the next edge. out_valid is high for exactly 1 cycle.
- in_ready returns to 1 the cycle after result acceptance.
  - Minimum spacing between accepted vectors = NUM_CLASSES+1 cycles.
- Downstream stall (out_ready=0) holds DONE indefinitely, with outputs stable.
- All outputs are registered except in_ready and busy, which decode state.

## Test plan
- Basic, default parameters:
  - Stimulus: logits k = 10*k for k=0..9, with out_ready=1.
  - Required: class_id=9, max_logit=90; out_valid rises 9 edges after acceptance and lasts 1 cycle; in_ready=0 throughout.
- Signed handling:
  - Stimulus: element 3 = 16'h7FFF, element 5 = 16'h8000, all others 0.
  - Required: class_id=3, max_logit=16'h7FFF.
  - Also, all elements negative with element 7 = -1 (16'hFFFF) -> class_id=7.
- Ties:
  - Stimulus 1: elements 2 and 6 both 500, others 100. Required: class_id=2.
  - Stimulus 2: all elements equal 42. Required: class_id=0, max_logit=42.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid rises, toggling logits and in_valid meanwhile.
  - Required: outputs stable, in_ready=0, no new capture. Releasing out_ready completes one acceptance; in_ready=1 the next cycle.
- Reset mid-scan:
  - Stimulus: assert rst 4 edges after acceptance, asynchronously between edges.
  - Required: out_valid=0, class_id=0, max_logit=0, in_ready=1 immediately. A vector presented after release returns its own correct argmax with no residue from the aborted scan.
- Back-to-back vectors:
  - Stimulus: in_valid held high with a new vector ready each time in_ready rises, and out_ready=1.
  - Required: vectors are accepted exactly every 11 cycles, each result is correct, and none are dropped or duplicated.
